// File: rtl/varint_encoder_param.sv
// Protobuf base-128 varint encoder: takes DATA_W-bit words and emits 7-bit groups
// LSB-first, one byte per cycle, with optional per-word zigzag mapping for signed fields.
module varint_encoder_param #(
  parameter int DATA_W    = 64,
  parameter int ZIGZAG_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_zigzag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [3:0]        out_len,
  output logic [31:0]       word_cnt,
  output logic              busy
);

  localparam int   MAX_B = (DATA_W + 6) / 7;
  localparam logic ZZ_ON = (ZIGZAG_EN != 0);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [3:0]        r_len;
  logic [31:0]       r_word_cnt;

  logic              w_emit;
  logic              w_more;
  logic              w_zz;
  logic              w_in_xfer;
  logic [DATA_W-1:0] w_load;

  // Zigzag: sign bit folded into the LSB so small magnitudes stay short.
  function automatic logic [DATA_W-1:0] zigzag(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] s;
    s = (x <<< 1) ^ (x >>> (DATA_W - 1));
    return s;
  endfunction

  assign w_emit    = (r_state == EMIT);
  assign w_more    = (|r_data[DATA_W-1:7]) && (r_len < 4'(MAX_B));
  assign w_zz      = ZZ_ON & in_zigzag;
  assign w_load    = w_zz ? zigzag(in_data) : in_data;
  assign in_ready  = ~w_emit | (~w_more & out_ready);
  assign w_in_xfer = in_valid & in_ready;

  // Outputs decode only registered state, so they hold steady under backpressure.
  assign out_valid = w_emit;
  assign out_byte  = w_emit ? {w_more, r_data[6:0]} : 8'h00;
  assign out_last  = w_emit & ~w_more;
  assign out_len   = (w_emit & ~w_more) ? r_len : 4'd0;
  assign word_cnt  = r_word_cnt;
  assign busy      = w_emit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_len      <= 4'd0;
      r_word_cnt <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_xfer) begin
            r_data  <= w_load;
            r_len   <= 4'd1;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (w_more) begin
              r_data <= r_data >> 7;
              r_len  <= r_len + 4'd1;
            end else begin
              r_word_cnt <= r_word_cnt + 32'd1;
              // Last byte leaving: chain straight into the next word if one is offered.
              if (w_in_xfer) begin
                r_data <= w_load;
                r_len  <= 4'd1;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_varint_encoder_param.sv
// Directed bench for varint_encoder_param: 32-bit, 64-bit zigzag and 64-bit
// zigzag-disabled instances sharing one clock and reset.
module tb_varint_encoder_param;

  logic        clk;
  logic        reset;
  logic [63:0] idata;
  logic        iz;
  logic        iv   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ol   [3];
  logic        bsy  [3];
  logic [7:0]  ob   [3];
  logic [3:0]  olen [3];
  logic [31:0] wc   [3];

  int n_tot = 0;
  int n_bad = 0;

  varint_encoder_param #(.DATA_W(32), .ZIGZAG_EN(1)) u_d32 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(idata[31:0]), .in_zigzag(iz), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_byte(ob[0]), .out_last(ol[0]), .out_len(olen[0]), .word_cnt(wc[0]), .busy(bsy[0])
  );

  varint_encoder_param #(.DATA_W(64), .ZIGZAG_EN(1)) u_d64 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(idata), .in_zigzag(iz), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_byte(ob[1]), .out_last(ol[1]), .out_len(olen[1]), .word_cnt(wc[1]), .busy(bsy[1])
  );

  varint_encoder_param #(.DATA_W(64), .ZIGZAG_EN(0)) u_d64_nz (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(idata), .in_zigzag(iz), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_byte(ob[2]), .out_last(ol[2]), .out_len(olen[2]), .word_cnt(wc[2]), .busy(bsy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Push one word into instance d and check its n bytes (packed LSB-first in exp).
  task automatic enc(input int d, input logic [63:0] x, input logic zz,
                     input logic [79:0] exp, input int n, input bit stall);
    int k;
    int guard;
    bit held;
    logic [12:0] hv;
    k = 0; guard = 0; held = 0; hv = '0;
    @(negedge clk);
    check_val("in_ready_idle", ir[d], 1'b1);
    iv[d] = 1'b1; idata = x; iz = zz; ordy[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0; iz = 1'b0;
    ordy[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    while (k < n && guard < 200) begin
      @(negedge clk);
      if (held) check_val("hold", {ob[d], ol[d], olen[d]}, hv);
      held = 0;
      check_val("out_valid", ov[d], 1'b1);
      check_val("busy", bsy[d], 1'b1);
      if (ordy[d]) begin
        check_val("byte", ob[d], exp[8*k +: 8]);
        check_val("last", ol[d], (k == n - 1));
        check_val("len", olen[d], (k == n - 1) ? n : 0);
        k++;
      end else begin
        held = 1;
        hv = {ob[d], ol[d], olen[d]};
      end
      @(posedge clk); #1;
      guard++;
      ordy[d] = (stall && guard < 30) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (k < n) check_val("timeout", k, n);
    ordy[d] = 1'b1;
    @(negedge clk);
    check_val("idle_after", ov[d], 1'b0);
  endtask

  initial begin
    reset = 1'b1; idata = '0; iz = 1'b0;
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b1; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val("rst_valid", ov[i], 1'b0);
      check_val("rst_byte", ob[i], 8'h00);
      check_val("rst_last", ol[i], 1'b0);
      check_val("rst_len", olen[i], 4'd0);
      check_val("rst_cnt", wc[i], 32'd0);
      check_val("rst_busy", bsy[i], 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_val("rel_ready", ir[i], 1'b1);

    // 32-bit basics
    enc(0, 64'd300, 1'b0, 80'h02AC, 2, 0);
    check_val("cnt_300", wc[0], 32'd1);
    enc(0, 64'd0, 1'b0, 80'h00, 1, 0);
    enc(0, 64'hFFFF_FFFF, 1'b0, 80'h0F_FF_FF_FF_FF, 5, 0);
    enc(0, 64'hFFFF_FFFF, 1'b1, 80'h01, 1, 0);
    check_val("cnt_d32", wc[0], 32'd4);

    // 64-bit zigzag
    enc(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 80'h01, 1, 0);
    enc(1, 64'd1, 1'b1, 80'h02, 1, 0);
    enc(1, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 80'h7F, 1, 0);
    enc(1, 64'd64, 1'b1, 80'h0180, 2, 0);
    enc(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF, 10, 0);
    check_val("cnt_d64", wc[1], 32'd5);

    // zigzag disabled: in_zigzag ignored
    enc(2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF, 10, 0);
    enc(2, 64'd64, 1'b1, 80'h40, 1, 0);
    check_val("cnt_nz", wc[2], 32'd2);

    // back-to-back 1,2,3 with in_valid held
    @(posedge clk); #1;
    iv[1] = 1'b1; idata = 64'd1;
    @(posedge clk); #1;
    idata = 64'd2;
    @(negedge clk);
    check_val("b2b_1", ob[1], 8'h01);
    check_val("b2b_1_last", ol[1], 1'b1);
    check_val("b2b_ready", ir[1], 1'b1);
    @(posedge clk); #1;
    idata = 64'd3;
    @(negedge clk);
    check_val("b2b_2", ob[1], 8'h02);
    check_val("b2b_2_valid", ov[1], 1'b1);
    @(posedge clk); #1;
    iv[1] = 1'b0;
    @(negedge clk);
    check_val("b2b_3", ob[1], 8'h03);
    check_val("b2b_3_valid", ov[1], 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("b2b_idle", ov[1], 1'b0);
    check_val("cnt_b2b", wc[1], 32'd8);

    // stalls during 300
    enc(0, 64'd300, 1'b0, 80'h02AC, 2, 1);
    enc(0, 64'hFFFF_FFFF, 1'b0, 80'h0F_FF_FF_FF_FF, 5, 1);
    check_val("cnt_stall", wc[0], 32'd6);

    // word held upstream while mid-varint
    @(posedge clk); #1;
    iv[0] = 1'b1; idata = 64'd300;
    @(posedge clk); #1;
    idata = 64'd5;
    @(negedge clk);
    check_val("mid_not_ready", ir[0], 1'b0);
    check_val("mid_byte", ob[0], 8'hAC);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("mid_last_byte", ob[0], 8'h02);
    check_val("mid_last_ready", ir[0], 1'b1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    check_val("mid_next", ob[0], 8'h05);
    @(posedge clk); #1;
    check_val("cnt_mid", wc[0], 32'd8);

    // async reset during byte 2 of 0xFFFF_FFFF
    iv[0] = 1'b1; idata = 64'hFFFF_FFFF;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    check_val("pre_rst_b1", ob[0], 8'hFF);
    @(posedge clk); #2;
    check_val("pre_rst_b2", ov[0], 1'b1);
    reset = 1'b1;
    #1;
    check_val("async_valid", ov[0], 1'b0);
    check_val("async_cnt", wc[0], 32'd0);
    check_val("async_busy", bsy[0], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", ir[0], 1'b1);
    check_val("post_rst_valid", ov[0], 1'b0);
    enc(0, 64'd300, 1'b0, 80'h02AC, 2, 0);
    check_val("post_rst_cnt", wc[0], 32'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
